// File: rtl/tt_probe_pkg.sv
// Shared types and helpers for the truth-table probe: FSM state encoding,
// the supported input-count ceiling and the table-width function.
package tt_probe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam int TT_MAX_IN = 4;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each probe pattern is held
// before sampling; 'expired' is high once the count has reached zero.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CW'(SETTLE_CYCLES - 1);
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps every input pattern into an N-input gate and rebuilds its truth-table
// code (pattern 0 in the MSB). Optional expected-code compare: TT_PROBE_COMPARE_EN.
module truth_table_probe
  import tt_probe_pkg::*;
#(
  parameter int  N_IN          = 3,
  parameter int  SETTLE_CYCLES = 4,
  localparam int TT_W          = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] probe_in,
  input  logic            probe_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            tt_valid
`ifdef TT_PROBE_COMPARE_EN
  ,
  input  logic [TT_W-1:0] tt_expect,
  output logic            tt_mismatch
`endif
);

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] pattern_q, pattern_d;
  logic [N_IN-1:0] probe_in_q, probe_in_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tt_valid_q, tt_valid_d;
  logic            start_accept;
  logic            timer_load;
  logic            timer_expired;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (state_q == DRIVE),
    .expired(timer_expired)
  );

  // Results are shifted in from the LSB, so after TT_W samples pattern 0 sits in the MSB.
  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    tt_d         = tt_q;
    tt_valid_d   = tt_valid_q;
    timer_load   = 1'b0;
    start_accept = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      tt_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            start_accept = 1'b1;
            state_d      = DRIVE;
            pattern_d    = '0;
            tt_d         = '0;
            tt_valid_d   = 1'b0;
            timer_load   = 1'b1;
          end
        end
        DRIVE: begin
          if (timer_expired) begin
            state_d = SAMPLE;
          end
        end
        SAMPLE: begin
          tt_d = {tt_q[TT_W-2:0], probe_out};
          if (&pattern_q) begin
            state_d    = DONE;
            tt_valid_d = 1'b1;
          end else begin
            state_d    = DRIVE;
            pattern_d  = pattern_q + N_IN'(1);
            timer_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d     = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d     = (state_d == DONE) && (state_q != DONE);
    probe_in_d = busy_d ? pattern_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pattern_q  <= '0;
      probe_in_q <= '0;
      tt_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      probe_in_q <= probe_in_d;
      tt_q       <= tt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tt_valid_q <= tt_valid_d;
    end
  end

  assign probe_in = probe_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tt       = tt_q;
  assign tt_valid = tt_valid_q;

`ifdef TT_PROBE_COMPARE_EN
  logic [TT_W-1:0] tt_expect_q, tt_expect_d;
  logic            tt_mismatch_q, tt_mismatch_d;

  // The expected code is captured with the start so it cannot drift mid-sweep.
  always_comb begin
    tt_expect_d   = tt_expect_q;
    tt_mismatch_d = tt_mismatch_q;
    if (start_accept) begin
      tt_expect_d = tt_expect;
    end
    if (!tt_valid_d) begin
      tt_mismatch_d = 1'b0;
    end
    if (done_d) begin
      tt_mismatch_d = (tt_d != tt_expect_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_expect_q   <= '0;
      tt_mismatch_q <= 1'b0;
    end else begin
      tt_expect_q   <= tt_expect_d;
      tt_mismatch_q <= tt_mismatch_d;
    end
  end

  assign tt_mismatch = tt_mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_probe.sv
// Randomized self-checking bench for truth_table_probe: a behavioural gate model
// and arithmetic timing model predict every output cycle by cycle.
module tb_truth_table_probe;

  localparam int S   = 4;
  localparam int TW  = 8;
  localparam int L   = TW * (S + 1);
  localparam int S2  = 1;
  localparam int TW2 = 4;
  localparam int L2  = TW2 * (S2 + 1);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] probe_in;
  logic       probe_out;
  logic       busy, done, tt_valid;
  logic [7:0] tt;
  logic [7:0] gate_code = 8'h00;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic [1:0] probe_in2;
  logic       probe_out2;
  logic       busy2, done2, tt_valid2;
  logic [3:0] tt2;
  logic [3:0] gate_code2 = 4'b0110;

`ifdef TT_PROBE_COMPARE_EN
  logic [7:0] tt_expect  = 8'h00;
  logic       tt_mismatch;
  logic [3:0] tt_expect2 = 4'h0;
  logic       tt_mismatch2;
`endif

  int errors = 0;
  int checks = 0;

  // Gate model: output for pattern p is code bit (width-1-p).
  assign probe_out  = gate_code[3'd7 - probe_in];
  assign probe_out2 = gate_code2[2'd3 - probe_in2];

  always #5 clk = ~clk;

  truth_table_probe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .probe_in (probe_in),
    .probe_out(probe_out),
    .busy     (busy),
    .done     (done),
    .tt       (tt),
    .tt_valid (tt_valid)
`ifdef TT_PROBE_COMPARE_EN
    ,
    .tt_expect  (tt_expect),
    .tt_mismatch(tt_mismatch)
`endif
  );

  truth_table_probe #(.N_IN(2), .SETTLE_CYCLES(1)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .abort    (abort2),
    .probe_in (probe_in2),
    .probe_out(probe_out2),
    .busy     (busy2),
    .done     (done2),
    .tt       (tt2),
    .tt_valid (tt_valid2)
`ifdef TT_PROBE_COMPARE_EN
    ,
    .tt_expect  (tt_expect2),
    .tt_mismatch(tt_mismatch2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One sweep of the default instance; abort_at < 0 means run to completion.
  task automatic applyStimulus(input logic [7:0] code, input logic [7:0] expect_code,
                               input int abort_at, input bit noisy_start);
    gate_code = code;
`ifdef TT_PROBE_COMPARE_EN
    tt_expect = expect_code;
`endif
    start = 1'b1;
    stepCycle();
    start = 1'b0;
`ifdef TT_PROBE_COMPARE_EN
    tt_expect = ~expect_code;
`endif
    for (int k = 0; k <= L; k++) begin
      if (k < L) begin
        checkOutput("sweep_busy", busy, 1);
        checkOutput("sweep_probe_in", probe_in, k / (S + 1));
        checkOutput("sweep_done", done, 0);
        checkOutput("sweep_tt_valid", tt_valid, 0);
`ifdef TT_PROBE_COMPARE_EN
        checkOutput("sweep_mismatch", tt_mismatch, 0);
`endif
        if (k == abort_at) begin
          start = 1'b0;
          abort = 1'b1;
          stepCycle();
          abort = 1'b0;
          for (int j = 0; j < 4; j++) begin
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_done", done, 0);
            checkOutput("abort_tt_valid", tt_valid, 0);
            checkOutput("abort_probe_in", probe_in, 0);
`ifdef TT_PROBE_COMPARE_EN
            checkOutput("abort_mismatch", tt_mismatch, 0);
`endif
            stepCycle();
          end
          return;
        end
        start = noisy_start ? ($urandom_range(0, 2) == 0) : 1'b0;
      end else begin
        start = 1'b0;
        checkOutput("done_pulse", done, 1);
        checkOutput("done_tt_valid", tt_valid, 1);
        checkOutput("done_tt", tt, code);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_probe_in", probe_in, 0);
`ifdef TT_PROBE_COMPARE_EN
        checkOutput("done_mismatch", tt_mismatch, (expect_code != code));
`endif
      end
      stepCycle();
    end
    checkOutput("after_done_pulse", done, 0);
    checkOutput("after_tt_valid", tt_valid, 1);
    checkOutput("after_tt", tt, code);
  endtask

  initial begin
    logic [7:0] codes [4];
    logic [7:0] rnd_code;
    logic [7:0] rnd_exp;
    int         ab;

    codes[0] = 8'h00;
    codes[1] = 8'hFF;
    codes[2] = 8'h01;
    codes[3] = 8'h80;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_probe_in", probe_in, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_tt", tt, 0);
    checkOutput("reset_tt_valid", tt_valid, 0);
    checkOutput("reset2_busy", busy2, 0);
    checkOutput("reset2_tt", tt2, 0);
`ifdef TT_PROBE_COMPARE_EN
    checkOutput("reset_mismatch", tt_mismatch, 0);
`endif
    rst_n = 1'b1;
    repeat (3) stepCycle();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_probe_in", probe_in, 0);

    applyStimulus(8'hBE, 8'hBE, -1, 1'b0);
    repeat (3) stepCycle();
    checkOutput("hold_tt", tt, 8'hBE);
    checkOutput("hold_tt_valid", tt_valid, 1);
    checkOutput("hold_done", done, 0);

    foreach (codes[i]) applyStimulus(codes[i], codes[i], -1, 1'b1);

    applyStimulus(8'hBE, 8'hBF, -1, 1'b0);

    applyStimulus(8'hBE, 8'hBE, 17, 1'b0);
    applyStimulus(8'hBE, 8'hBE, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rnd_code = 8'($urandom);
      rnd_exp  = ($urandom_range(0, 1) == 0) ? rnd_code : 8'($urandom);
      ab       = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      applyStimulus(rnd_code, rnd_exp, ab, 1'b1);
    end

    // start and abort together while DONE: abort wins.
    applyStimulus(8'h5A, 8'h00, -1, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("sa_busy", busy, 0);
    checkOutput("sa_tt_valid", tt_valid, 0);
    checkOutput("sa_done", done, 0);
    checkOutput("sa_probe_in", probe_in, 0);
`ifdef TT_PROBE_COMPARE_EN
    checkOutput("sa_mismatch", tt_mismatch, 0);
`endif
    stepCycle();
    checkOutput("sa_stay_idle", busy, 0);

    // Asynchronous reset between edges during DRIVE of pattern 1.
    gate_code = 8'hBE;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (7) stepCycle();
    checkOutput("pre_rst_busy", busy, 1);
    checkOutput("pre_rst_probe_in", probe_in, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_probe_in", probe_in, 0);
    checkOutput("arst_tt", tt, 0);
    checkOutput("arst_tt_valid", tt_valid, 0);
    checkOutput("arst_done", done, 0);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      stepCycle();
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_probe_in", probe_in, 0);
      checkOutput("post_rst_done", done, 0);
    end
    applyStimulus(8'hBE, 8'hBE, -1, 1'b0);

    // Two-input XOR on the small instance.
`ifdef TT_PROBE_COMPARE_EN
    tt_expect2 = 4'b0110;
`endif
    start2 = 1'b1;
    stepCycle();
    start2 = 1'b0;
    for (int k = 0; k <= L2; k++) begin
      if (k < L2) begin
        checkOutput("xor_busy", busy2, 1);
        checkOutput("xor_probe_in", probe_in2, k / (S2 + 1));
        checkOutput("xor_done", done2, 0);
      end else begin
        checkOutput("xor_done_pulse", done2, 1);
        checkOutput("xor_tt", tt2, 4'b0110);
        checkOutput("xor_tt_valid", tt_valid2, 1);
        checkOutput("xor_busy_end", busy2, 0);
`ifdef TT_PROBE_COMPARE_EN
        checkOutput("xor_mismatch", tt_mismatch2, 0);
`endif
      end
      stepCycle();
    end
    checkOutput("xor_after_done", done2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
